// File: rtl/mel_frame_buffer_pkg.sv
// Shared types and defaults for the mel spectrogram frame buffer.
// Tile layout is mel-major: element [m][f] sits at flat index m*frames+f.
package mel_frame_pkg;

  localparam int DATA_WIDTH         = 16;
  localparam int N_MELS             = 2;
  localparam int FIXED_FRAMES_FINAL = 4;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } mfb_state_e;

  function automatic int idx(input int m, input int f,
                             input int n_frames = FIXED_FRAMES_FINAL);
    return m * n_frames + f;
  endfunction

endpackage

// File: rtl/mel_frame_buffer_cdc_sync2.sv
// Two-flop synchronizer for a single slow control bit; the reset value
// is chosen so the synchronized signal starts in its inactive level.
module cdc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mel_frame_buffer.sv
// Double-buffered mel tile collector feeding the SPI slave's parallel data_in.
// Optional macro MFB_SEQ_CNT_EN adds an 8-bit seq_cnt that counts bank swaps.
//
// Input handshake: a sample transfers on a rising clk edge where
// in_valid and in_ready are both high; in_valid may be raised at any time
// and in_ready does not depend on in_valid.
module mel_frame_buffer #(
  parameter int DATA_WIDTH         = mel_frame_pkg::DATA_WIDTH,
  parameter int N_MELS             = mel_frame_pkg::N_MELS,
  parameter int FIXED_FRAMES_FINAL = mel_frame_pkg::FIXED_FRAMES_FINAL
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]                  in_data,
  input  logic                                          flush,
  input  logic                                          cs_n,
  output logic [N_MELS*FIXED_FRAMES_FINAL*DATA_WIDTH-1:0] data_out,
  output logic                                          frame_avail
`ifdef MFB_SEQ_CNT_EN
  ,
  output logic [7:0]                                    seq_cnt
`endif
);

  import mel_frame_pkg::*;

  localparam int NE = N_MELS * FIXED_FRAMES_FINAL;
  localparam int MW = (N_MELS > 1) ? $clog2(N_MELS) : 1;
  localparam int FW = (FIXED_FRAMES_FINAL > 1) ? $clog2(FIXED_FRAMES_FINAL) : 1;
  localparam int AW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [MW-1:0] MEL_LAST = MW'(N_MELS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FIXED_FRAMES_FINAL - 1);

  mfb_state_e state, state_nxt;

  logic [MW-1:0]         mel_idx;
  logic [FW-1:0]         frm_idx;
  logic [AW-1:0]         wr_addr;
  logic                  wr_sel;
  logic [DATA_WIDTH-1:0] bank0 [NE];
  logic [DATA_WIDTH-1:0] bank1 [NE];

  logic cs_s, cs_q, cs_idle, read_start;
  logic accept, last_acc, wr_en, swap;

  cdc_sync2 #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_q <= 1'b1;
    else        cs_q <= cs_s;
  end

  assign cs_idle    = cs_s;
  assign read_start = cs_q & ~cs_s;

  assign accept   = in_valid & in_ready;
  assign last_acc = accept & (mel_idx == MEL_LAST) & (frm_idx == FRM_LAST);
  assign wr_en    = accept & ~flush;
  assign wr_addr  = AW'(idx(int'(mel_idx), int'(frm_idx), FIXED_FRAMES_FINAL));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (!flush && last_acc && !cs_idle) state_nxt = HOLD;
      HOLD: if (flush || cs_idle) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // FSM: outputs; a swap requires a synchronized idle bus so no read is torn
  always_comb begin
    in_ready = 1'b0;
    swap     = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        swap     = ~flush & last_acc & cs_idle;
      end
      HOLD: swap = ~flush & cs_idle;
      default: ;
    endcase
  end

  // Arrival is frame-major, storage mel-major: indices walk mels fastest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mel_idx <= '0;
      frm_idx <= '0;
    end else if (flush || last_acc) begin
      mel_idx <= '0;
      frm_idx <= '0;
    end else if (accept) begin
      if (mel_idx == MEL_LAST) begin
        mel_idx <= '0;
        frm_idx <= frm_idx + 1'b1;
      end else begin
        mel_idx <= mel_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel) bank1[wr_addr] <= in_data;
      else        bank0[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel      <= 1'b0;
      frame_avail <= 1'b0;
    end else begin
      if (swap) wr_sel <= ~wr_sel;
      if (swap)            frame_avail <= 1'b1;
      else if (read_start) frame_avail <= 1'b0;
    end
  end

`ifdef MFB_SEQ_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    seq_cnt <= '0;
    else if (swap) seq_cnt <= seq_cnt + 8'd1;
  end
`endif

  // Read bank is whichever bank is not being written.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NE; i++) begin
      data_out[i*DATA_WIDTH +: DATA_WIDTH] = wr_sel ? bank0[i] : bank1[i];
    end
  end

endmodule

// File: tb/tb_mel_frame_buffer.sv
// Scoreboarded bench for mel_frame_buffer; define MFB_SEQ_CNT_EN to cover seq_cnt.
module tb_mel_frame_buffer;

  import mel_frame_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int NM = N_MELS;
  localparam int NF = FIXED_FRAMES_FINAL;
  localparam int NE = NM * NF;
  localparam int TW = NE * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          cs_n = 1'b1;
  logic          in_ready;
  logic          frame_avail;
  logic [TW-1:0] data_out;
`ifdef MFB_SEQ_CNT_EN
  logic [7:0]    seq_cnt;
`endif

  int            n_checks = 0;
  int            n_pass = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] last_out = '0;
  logic [TW-1:0] cur_tile = '0;
  sample_t       words[NE];

  mel_frame_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flush       (flush),
    .cs_n        (cs_n),
    .data_out    (data_out),
    .frame_avail (frame_avail)
`ifdef MFB_SEQ_CNT_EN
    ,
    .seq_cnt     (seq_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: word k of a tile arrives as frame k/NM, mel k%NM.
  function automatic logic [TW-1:0] tile_of(input sample_t w[NE]);
    logic [TW-1:0] t;
    t = '0;
    for (int f = 0; f < NF; f++)
      for (int m = 0; m < NM; m++)
        t[(m*NF+f)*DW +: DW] = w[f*NM+m];
    return t;
  endfunction

  task automatic make_words(input int seed);
    logic [7:0] s;
    s = seed[7:0];
    for (int i = 0; i < NE; i++) words[i] = sample_t'({s, 8'(i + 1)});
  endtask

  // driver tasks: inputs change 1 unit after the rising edge
  task automatic send_word(input logic [DW-1:0] d);
    int budget;
    budget = 20;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_tile();
    for (int i = 0; i < NE; i++) send_word(words[i]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s: %0d tiles pending, required 0", name, exp_q.size());
  endtask

  // scoreboard monitor: every change of data_out outside reset is a swap
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = data_out;
    end else if (data_out !== last_out) begin
      last_out = data_out;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_swap: data_out %h with no tile pending", data_out);
      end else begin
        check("tile", data_out, exp_q.pop_front());
        check("frame_avail_on_swap", TW'(frame_avail), TW'(1));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data_out", data_out, '0);
    check("reset_frame_avail", TW'(frame_avail), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", TW'(in_ready), TW'(1));
    check("idle_data_out", data_out, '0);
    check("idle_frame_avail", TW'(frame_avail), '0);

    // tile 1, bus idle: swaps on the last accept
    words = '{16'hAAAA, 16'h8001, 16'h1234, 16'h7FFF,
              16'h0F0F, 16'h55AA, 16'h00FF, 16'hDEAD};
    cur_tile = 128'hDEAD_55AA_7FFF_8001_00FF_0F0F_1234_AAAA;
    exp_q.push_back(cur_tile);
    send_tile();
    check("tile1_frame_avail", TW'(frame_avail), TW'(1));
    wait_drain("tile1_swap", 2);
`ifdef MFB_SEQ_CNT_EN
    check("seq_cnt_tile1", TW'(seq_cnt), TW'(1));
`endif

    // host read in progress: tile 2 must wait in HOLD
    cs_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("read_clears_frame_avail", TW'(frame_avail), '0);
    make_words(2);
    send_tile();
    check("hold_in_ready", TW'(in_ready), '0);
    repeat (4) @(posedge clk);
    #1;
    check("hold_data_stable", data_out, cur_tile);
    check("hold_in_ready_still", TW'(in_ready), '0);
    cur_tile = tile_of(words);
    exp_q.push_back(cur_tile);
    cs_n = 1'b1;
    wait_drain("swap_after_cs_rise", 5);
    check("after_swap_in_ready", TW'(in_ready), TW'(1));
    check("after_swap_frame_avail", TW'(frame_avail), TW'(1));

    // flush in HOLD discards the held tile
    cs_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    make_words(3);
    send_tile();
    check("hold2_in_ready", TW'(in_ready), '0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("hold_flush_in_ready", TW'(in_ready), TW'(1));
    cs_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("hold_flush_no_swap_data", data_out, cur_tile);
    check("hold_flush_no_swap_avail", TW'(frame_avail), '0);

    // flush mid-tile, then a fresh tile
    make_words(4);
    for (int i = 0; i < 3; i++) send_word(words[i]);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_mid_data_stable", data_out, cur_tile);
    make_words(5);
    cur_tile = tile_of(words);
    exp_q.push_back(cur_tile);
    send_tile();
    wait_drain("flush_mid_fresh_tile", 2);

    // flush coinciding with the last accept drops the word and the tile
    make_words(6);
    for (int i = 0; i < NE - 1; i++) send_word(words[i]);
    in_valid = 1'b1;
    in_data  = words[NE-1];
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_last_no_swap", data_out, cur_tile);
    make_words(7);
    cur_tile = tile_of(words);
    exp_q.push_back(cur_tile);
    send_tile();
    wait_drain("after_flush_last_tile", 2);

    // asynchronous reset in the middle of a fill
    make_words(8);
    for (int i = 0; i < 3; i++) send_word(words[i]);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_data_out", data_out, '0);
    check("async_reset_frame_avail", TW'(frame_avail), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", TW'(in_ready), TW'(1));
    make_words(9);
    cur_tile = tile_of(words);
    exp_q.push_back(cur_tile);
    send_tile();
    wait_drain("post_reset_tile", 2);
`ifdef MFB_SEQ_CNT_EN
    check("seq_cnt_after_reset", TW'(seq_cnt), TW'(1));
    // 256 more tiles: 257 swaps since reset wraps the counter to 1
    for (int t = 0; t < 256; t++) begin
      make_words(16 + t);
      exp_q.push_back(tile_of(words));
      send_tile();
      wait_drain("seq_tile", 3);
    end
    check("seq_cnt_wrapped", TW'(seq_cnt), TW'(1));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", TW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
